serial_add_datapath: RTL

Datapath half of the serial adder. It consumes the controller's rst_n, load and enable strobes. On load it captures two W-bit operands, then adds them LSB-first, one bit per enable cycle, through a single full-adder bit and a carry flip-flop. After W+1 enables it publishes the (W+1)-bit sum with a one-cycle valid pulse. With the default W=10, this matches the controller's 1 reset, 1 load and 11 enable sequence.

---
 rtl/serial_add_pkg.sv | 16 +
 rtl/serial_fa_bit.sv | 16 +
 rtl/serial_add_datapath.sv | 110 +++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial adder datapath.
//   DEF_W    : default operand width
//   cnt_w()  : bits needed for a step counter that reaches w+1
//   CNT_W    : counter width for the default operand width
package serial_add_pkg;

    localparam int unsigned DEF_W = 10;

    // The counter must represent 0..w+1, so size it for w+2 distinct values.
    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w + 2);
    endfunction

    localparam int unsigned CNT_W = $clog2(DEF_W + 2);

endpackage

// File: rtl/serial_fa_bit.sv
// Single-bit combinational full adder used for the serial bit step.
//   i_a, i_b, i_cin : addend bits and carry in
//   o_s             : sum bit
//   o_cout          : carry out (majority of the three inputs)
module serial_fa_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_add_datapath.sv
// Datapath half of the serial adder. Captures two W-bit operands on load, then adds
// them LSB-first, one bit per enable, through a single full adder and carry flop.
// The (W+1)-th enable publishes the W+1 bit sum with a one-cycle valid pulse.
//   clk_i, rst_i   : clock, asynchronous active-low reset (clears everything)
//   rst_n          : synchronous active-low clear of working state (keeps sum_o)
//   load, enable   : capture operands / perform one bit step (load wins)
//   a_i, b_i       : operands, sampled on load only
//   sum_o          : last completed sum, held until the next completion
//   sum_valid_o    : one-cycle pulse with each sum_o update
//   busy_o         : high from load until completion
//   serial_o       : sum bit produced by the most recent step
module serial_add_datapath
    import serial_add_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         rst_n,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W:0]   sum_o,
    output logic         sum_valid_o,
    output logic         busy_o,
    output logic         serial_o
);

    localparam int unsigned CW = cnt_w(W);

    logic [W-1:0]  r_a_sh;
    logic [W-1:0]  r_b_sh;
    logic          r_carry;
    // Upper W bits of the partial sum; the lowest bit of a full W+1 shifter is
    // shifted out unread on every step, so it is not stored.
    logic [W-1:0]  r_sum_sh;
    logic [CW-1:0] r_cnt;
    logic          r_armed;
    logic [W:0]    r_sum;
    logic          r_sum_valid;
    logic          r_serial;

    logic          w_s;
    logic          w_c;
    logic          w_step;
    logic          w_last;

    serial_fa_bit u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_c)
    );

    assign w_step = enable & r_armed;
    assign w_last = (r_cnt == CW'(W));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_carry     <= 1'b0;
            r_sum_sh    <= '0;
            r_cnt       <= '0;
            r_armed     <= 1'b0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
            r_serial    <= 1'b0;
        end else begin
            r_sum_valid <= 1'b0;
            if (!rst_n) begin
                // sum_o is intentionally kept: the controller idles with rst_n low.
                r_a_sh   <= '0;
                r_b_sh   <= '0;
                r_carry  <= 1'b0;
                r_sum_sh <= '0;
                r_cnt    <= '0;
                r_armed  <= 1'b0;
                r_serial <= 1'b0;
            end else if (load) begin
                r_a_sh   <= a_i;
                r_b_sh   <= b_i;
                r_carry  <= 1'b0;
                r_sum_sh <= '0;
                r_cnt    <= '0;
                r_armed  <= 1'b1;
            end else if (w_step) begin
                r_a_sh   <= {1'b0, r_a_sh[W-1:1]};
                r_b_sh   <= {1'b0, r_b_sh[W-1:1]};
                r_sum_sh <= {w_s, r_sum_sh[W-1:1]};
                r_carry  <= w_c;
                r_serial <= w_s;
                r_cnt    <= r_cnt + 1'b1;
                if (w_last) begin
                    r_sum       <= {w_s, r_sum_sh};
                    r_sum_valid <= 1'b1;
                    r_armed     <= 1'b0;
                end
            end
        end
    end

    assign sum_o       = r_sum;
    assign sum_valid_o = r_sum_valid;
    assign busy_o      = r_armed;
    assign serial_o    = r_serial;

endmodule
